timer_counter: RTL
==================

Name: timer_counter

Overview:
- Counting core of the timer, directly downstream of the register block that holds TDR (addr 8'h00) and TCR.
- Consumes the TDR reload value and the TCR control fields (enable, up/down, clock select).
- Produces the live count value and one-cycle overflow/underflow pulses.
- Those pulses feed the status register and the interrupt handler.

Parameters:
- CNT_W, 8, counter width; equals TDR width.
- PSC_W, 4, prescaler width; sets the maximum division of 16.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- load_i  input  1  one-cycle pulse from the register block; reloads the counter from tdr_i.
- tdr_i  input  CNT_W  TDR value.
- en_i  input  1  TCR enable.
- down_i  input  1  TCR direction: 0 = count up, 1 = count down.
- cks_i  input  2  TCR clock select: 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- cnt_o  output  CNT_W  current count (TCNT).
- ovf_o  output  1  one-cycle overflow pulse.
- udf_o  output  1  one-cycle underflow pulse.

Behaviour:
- Reset (rst_n low, asynchronous): cnt_o = 0, ovf_o = 0, udf_o = 0, prescaler = 0. All outputs come straight from registers.
- Prescaler:
  - PSC_W-bit counter; increments every clk while en_i = 1.
  - Holds its value while en_i = 0.
  - Cleared to 0 on load_i.
- Tick:
  - Combinational: tick = en_i AND (low cks_i+1 bits of the prescaler all ones).
  - Result: one tick every 2/4/8/16 clk.
  - A change of cks_i takes effect immediately. The prescaler is not cleared, so the first period after the change may be short.
- Counter update on each clk edge, in priority order:
  1. load_i: cnt <= tdr_i. Any same-cycle tick is discarded; no ovf/udf pulse.
  2. tick with down_i = 0: cnt <= cnt + 1. At 0xFF it wraps to 0x00 and ovf_o = 1 next cycle.
  3. tick with down_i = 1: cnt <= cnt − 1. At 0x00 it wraps to 0xFF and udf_o = 1 next cycle.
  4. Otherwise cnt holds.
- ovf_o/udf_o are high for exactly one cycle, coincident with the wrapped cnt_o value. They never assert together.
- Arithmetic is modulo 2^CNT_W. No saturation.
- load_i is accepted even with en_i = 0. The count then stays at tdr_i until enabled.
- A change of down_i takes effect at the next tick.
- With en_i = 0, cnt_o and the prescaler freeze; pulses deassert the following cycle.
- Reset mid-count returns all state to reset values immediately.
- Sticky flag storage and interrupt masking are owned by the register/interrupt blocks, not this block.

Optional Feature:
- Macro TIMER_CMP_EN.
- When defined, adds two ports:
  - cmp_i  input  CNT_W  compare value.
  - cmp_o  output  1  compare-match pulse, reset 0.
- cmp_o goes high for one cycle when a tick (not a load) makes cnt equal cmp_i, coincident with that new cnt_o value.
- When undefined, both ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Shared include timer_defs.vh holds:
  - CKS encodings: CKS_DIV2, CKS_DIV4, CKS_DIV8, CKS_DIV16.
  - Direction constants: DIR_UP, DIR_DOWN.
  - Default CNT_W.
  - TDR/TCR address constants (8'h00/8'h01).
- One sub-module, timer_prescaler: inputs clk, rst_n, en_i, clr_i (= load_i), cks_i; output tick_o.
- The counter, wrap detection and pulses stay in timer_counter.

Test Plan:
- Reset then idle: cnt_o = 0x00, ovf_o = udf_o = 0 for 100 clk with en_i = 0.
- Up, divide by 2: load tdr_i = 0xFC, then en_i = 1, cks = 00.
  - cnt_o steps FD, FE, FF, 00 every 2 clk.
  - ovf_o = 1 for exactly one cycle, when cnt_o = 00.
- Down, divide by 16: load 0x01, cks = 11, down_i = 1.
  - cnt_o = 00 after 16 clk, then FF after 32 clk.
  - udf_o pulses once, coincident with FF.
- Load/tick collision: with cnt = 0xFF and load_i asserted in a tick cycle with tdr_i = 0x10.
  - Next cnt_o = 0x10; no ovf_o pulse.
- Enable gating: en_i dropped mid-period at cnt = 0x42.
  - cnt_o holds 0x42 for 50 clk.
  - After re-enable, the first tick comes from the held prescaler value.
- (TIMER_CMP_EN) cmp_i = 0x05, count up from 0x00 with cks = 00.
  - cmp_o pulses once, when cnt_o = 0x05.
  - Loading 0x05 directly gives no pulse.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared timer definitions: clock-select encodings, direction constants,
// default widths and register-block addresses.
package timer_counter_pkg;

    // Default counter width (matches TDR) and prescaler width.
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned PSC_W_DEF = 4;

    // TCR clock-select encodings.
    localparam logic [1:0] CKS_DIV2  = 2'b00;
    localparam logic [1:0] CKS_DIV4  = 2'b01;
    localparam logic [1:0] CKS_DIV8  = 2'b10;
    localparam logic [1:0] CKS_DIV16 = 2'b11;

    // TCR direction field.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Register-block addresses for the registers feeding this core.
    localparam logic [7:0] TDR_ADDR = 8'h00;
    localparam logic [7:0] TCR_ADDR = 8'h01;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler for the timer. Produces a combinational tick once
// every 2/4/8/16 enabled clocks, selected by cks_i.
module timer_prescaler
    import timer_counter_pkg::*;
#(
    parameter int unsigned PSC_W = PSC_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] cks_i,
    output logic       tick_o
);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;
    logic [PSC_W-1:0] mask;
    int unsigned      nbits;

    // Select how many low prescaler bits must be all ones for a tick.
    always_comb begin
        nbits = 1;
        unique case (cks_i)
            CKS_DIV2:  nbits = 1;
            CKS_DIV4:  nbits = 2;
            CKS_DIV8:  nbits = 3;
            CKS_DIV16: nbits = 4;
            default:   nbits = 1;
        endcase
        mask = '0;
        for (int unsigned i = 0; i < PSC_W; i++) begin
            if (i < nbits) begin
                mask[i] = 1'b1;
            end
        end
    end

    // cks_i changes act immediately; the count itself is never cleared by them.
    assign tick_o = en_i & ((psc_q & mask) == mask);

    // Next prescaler value: clear on load, advance while enabled, else hold.
    always_comb begin
        psc_d = psc_q;
        if (clr_i) begin
            psc_d = '0;
        end else if (en_i) begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    // Prescaler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Timer counting core: reloadable up/down counter driven by the prescaler
// tick, with one-cycle overflow/underflow pulses aligned to the wrapped count.
// Optional compare-match output is built when TIMER_CMP_EN is defined.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] tdr_i,
    input  logic             en_i,
    input  logic             down_i,
    input  logic [1:0]       cks_i,
`ifdef TIMER_CMP_EN
    input  logic [CNT_W-1:0] cmp_i,
    output logic             cmp_o,
`endif
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o,
    output logic             udf_o
);

    logic             tick;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;

    timer_prescaler #(
        .PSC_W(PSC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .clr_i (load_i),
        .cks_i (cks_i),
        .tick_o(tick)
    );

    // Next count and wrap pulses; a load wins over a same-cycle tick.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (load_i) begin
            cnt_d = tdr_i;
        end else if (tick) begin
            if (down_i == DIR_UP) begin
                cnt_d = cnt_q + CNT_W'(1);
                ovf_d = (cnt_q == {CNT_W{1'b1}});
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
                udf_d = (cnt_q == '0);
            end
        end
    end

    // Count and pulse registers; pulses are valid alongside the new count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;
    assign udf_o = udf_q;

`ifdef TIMER_CMP_EN
    logic cmp_q;
    logic cmp_d;

    // Match only on counting, never on a direct load of the compare value.
    always_comb begin
        cmp_d = tick & ~load_i & (cnt_d == cmp_i);
    end

    // Compare-match pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    assign cmp_o = cmp_q;
`endif

endmodule
